// File: rtl/led_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_flash_pkg
// Desc     : Shared constants for the LED flash driver: FSM state encoding,
//            request count width and phase-counter sizing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package led_flash_pkg;

  // Width of the requested flash count (0..15 flashes)
  localparam int c_COUNT_W = 4;

  // Unit value in the flash count width, used for decrement and compare
  localparam logic [c_COUNT_W-1:0] c_COUNT_ONE = 4'd1;

  // FSM state encoding
  localparam int c_STATE_W = 2;
  localparam logic [c_STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [c_STATE_W-1:0] ST_ON   = 2'd1;
  localparam logic [c_STATE_W-1:0] ST_OFF  = 2'd2;

  // Larger of two integers, used for elaboration-time sizing
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Phase counter width: one bit of headroom above the longest phase so the
  // terminal compare can never be defeated by a wrap
  function automatic int phase_cnt_width(input int clks_on, input int clks_off);
    return $clog2(max_int(clks_on, clks_off)) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : led_phase_timer
// Desc     : Elapsed-cycle counter for the current LED phase. Clears on
//            request, advances on tick and flags the last cycle of the phase.
//            Debug mode makes every phase exactly one cycle long.
// Revision : 1.0 - initial release
// ============================================================================
module led_phase_timer
  import led_flash_pkg::*;
#(
  parameter int CLKS_ON  = 250000,
  parameter int CLKS_OFF = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  input  logic phase_off,
  input  logic debug,
  output logic tc
);

  localparam int c_CNT_W = phase_cnt_width(CLKS_ON, CLKS_OFF);
  localparam logic [c_CNT_W-1:0] c_ON_LAST  = c_CNT_W'(CLKS_ON - 1);
  localparam logic [c_CNT_W-1:0] c_OFF_LAST = c_CNT_W'(CLKS_OFF - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_last;
  logic               w_at_last;

  // Select the terminal value of the phase currently being timed
  always_comb begin
    w_last    = phase_off ? c_OFF_LAST : c_ON_LAST;
    w_at_last = (r_cnt >= w_last);
    tc        = debug | w_at_last;
  end

  // Elapsed-cycle counter; holds at the terminal value rather than wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (tick && !w_at_last) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_flash_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_flash_driver
// Desc     : Flashes an LED a requested number of times. Each flash is an
//            ON phase of CLKS_ON cycles followed by an OFF phase of CLKS_OFF
//            cycles; done pulses on the last OFF cycle of a sequence.
// Config   : LED_FLASH_QUEUE_EN - adds a one-entry pending-request buffer so
//            a request made while busy runs straight after the current one.
// Revision : 1.0 - initial release
// ============================================================================
module led_flash_driver
  import led_flash_pkg::*;
#(
  parameter int CLKS_ON  = 250000,
  parameter int CLKS_OFF = 250000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 e_debug,
  input  logic                 req_valid,
  input  logic [c_COUNT_W-1:0] req_count,
  output logic                 req_ready,
  output logic                 led_out,
  output logic                 busy,
  output logic                 done
);

  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_state_next;
  logic [c_COUNT_W-1:0] r_remaining;

  logic                 w_tc;
  logic                 w_timer_clear;
  logic                 w_accept;
  logic                 w_req_nz;
  logic                 w_final_end;
  logic                 w_chain;
  logic [c_COUNT_W-1:0] w_chain_count;

  // Request handshake and end-of-sequence decode
  always_comb begin
    w_accept    = req_valid & req_ready;
    w_req_nz    = (req_count != '0);
    w_final_end = (r_state == ST_OFF) & w_tc & (r_remaining == c_COUNT_ONE);
  end

`ifdef LED_FLASH_QUEUE_EN
  logic                 r_pend_valid;
  logic [c_COUNT_W-1:0] r_pend_count;
  logic                 w_chain_pend;
  logic                 w_chain_req;

  // Ready while idle or while the pending slot is free; a sequence ending
  // this cycle either resumes from the pending slot or takes a fresh request
  always_comb begin
    req_ready     = (r_state == ST_IDLE) | ~r_pend_valid;
    w_chain_pend  = w_final_end & r_pend_valid;
    w_chain_req   = w_final_end & ~r_pend_valid & w_accept & w_req_nz;
    w_chain       = w_chain_pend | w_chain_req;
    w_chain_count = r_pend_valid ? r_pend_count : req_count;
  end

  // Pending slot: filled by a nonzero request accepted mid-sequence, drained
  // when the running sequence finishes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_count <= '0;
    end else if (w_chain_pend) begin
      r_pend_valid <= 1'b0;
      r_pend_count <= '0;
    end else if (w_accept && w_req_nz && (r_state != ST_IDLE) && !w_final_end) begin
      r_pend_valid <= 1'b1;
      r_pend_count <= req_count;
    end
  end
`else
  // No buffering: requests are only taken while idle
  always_comb begin
    req_ready     = (r_state == ST_IDLE);
    w_chain       = 1'b0;
    w_chain_count = '0;
  end
`endif

  // Phase timer restarts whenever the state changes and is held clear in IDLE
  always_comb begin
    w_timer_clear = (w_state_next != r_state) | (r_state == ST_IDLE);
  end

  led_phase_timer #(
    .CLKS_ON  (CLKS_ON),
    .CLKS_OFF (CLKS_OFF)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_timer_clear),
    .tick      (busy),
    .phase_off (r_state == ST_OFF),
    .debug     (e_debug),
    .tc        (w_tc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_req_nz) begin
          w_state_next = ST_ON;
        end
      end
      ST_ON: begin
        if (w_tc) begin
          w_state_next = ST_OFF;
        end
      end
      ST_OFF: begin
        if (w_tc) begin
          if (r_remaining > c_COUNT_ONE) begin
            w_state_next = ST_ON;
          end else if (w_chain) begin
            w_state_next = ST_ON;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Remaining-flash counter: loaded on start, decremented at each OFF end,
  // reloaded when a chained request continues the sequence
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_remaining <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept && w_req_nz) begin
        r_remaining <= req_count;
      end
    end else if ((r_state == ST_OFF) && w_tc) begin
      if (r_remaining > c_COUNT_ONE) begin
        r_remaining <= r_remaining - c_COUNT_ONE;
      end else if (w_chain) begin
        r_remaining <= w_chain_count;
      end else begin
        r_remaining <= '0;
      end
    end
  end

  // FSM outputs; done is masked by reset so an aborted sequence never pulses
  always_comb begin
    led_out = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      ST_ON: begin
        led_out = 1'b1;
        busy    = 1'b1;
      end
      ST_OFF: begin
        busy = 1'b1;
        done = w_final_end & rst_n;
      end
      default: begin
        led_out = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_flash_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_flash_driver
// Desc     : Self-checking bench for led_flash_driver with CLKS_ON=4,
//            CLKS_OFF=3. Expected waveforms come from a timeline model: a
//            request accepted at cycle 0 with N flashes of period ON+OFF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_flash_driver;

  localparam int ON  = 4;
  localparam int OFF = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e_debug;
  logic       req_valid;
  logic [3:0] req_count;
  logic       req_ready;
  logic       led_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_flash_driver #(
    .CLKS_ON  (ON),
    .CLKS_OFF (OFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e_debug   (e_debug),
    .req_valid (req_valid),
    .req_count (req_count),
    .req_ready (req_ready),
    .led_out   (led_out),
    .busy      (busy),
    .done      (done)
  );

  // Timeline model: cycle t after an accept at cycle 0, n flashes
  function automatic bit m_led(int t, int n, int on, int off);
    int p;
    if (t < 1) return 1'b0;
    p = t - 1;
    if (p >= n * (on + off)) return 1'b0;
    return (p % (on + off)) < on;
  endfunction

  function automatic bit m_busy(int t, int n, int on, int off);
    if (t < 1) return 1'b0;
    return (t - 1) < n * (on + off);
  endfunction

  function automatic bit m_done(int t, int n, int on, int off);
    if (t < 1 || n == 0) return 1'b0;
    return (t - 1) == n * (on + off) - 1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; e_debug = 1'b0; req_valid = 1'b0; req_count = 4'd0;
    repeat (3) next_cycle();
    checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset led_out got %0b exp 0", led_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %0b exp 0", done); end
    rst_n = 1'b1;
    next_cycle();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %0b exp 1", req_ready); end
  endtask

  task automatic test_single_flash();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single ready0 got %0b exp 1", req_ready); end
    req_valid = 1'b1; req_count = 4'd2;
    for (int t = 1; t <= 16; t++) begin
      next_cycle();
      req_valid = 1'b0;
      checks++; if (led_out !== m_led(t, 2, ON, OFF)) begin errors++; $display("FAIL single t=%0d led got %0b exp %0b", t, led_out, m_led(t, 2, ON, OFF)); end
      checks++; if (busy !== m_busy(t, 2, ON, OFF)) begin errors++; $display("FAIL single t=%0d busy got %0b exp %0b", t, busy, m_busy(t, 2, ON, OFF)); end
      checks++; if (done !== m_done(t, 2, ON, OFF)) begin errors++; $display("FAIL single t=%0d done got %0b exp %0b", t, done, m_done(t, 2, ON, OFF)); end
    end
  endtask

  task automatic test_zero_count();
    req_valid = 1'b1; req_count = 4'd0;
    for (int t = 1; t <= 20; t++) begin
      next_cycle();
      req_valid = 1'b0;
      checks++; if ({led_out, busy, done} !== 3'b000) begin errors++; $display("FAIL zero t=%0d led/busy/done got %03b exp 000", t, {led_out, busy, done}); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero t=%0d ready got %0b exp 1", t, req_ready); end
    end
  endtask

  task automatic test_debug();
    e_debug = 1'b1;
    req_valid = 1'b1; req_count = 4'd3;
    for (int t = 1; t <= 8; t++) begin
      next_cycle();
      req_valid = 1'b0;
      checks++; if (led_out !== m_led(t, 3, 1, 1)) begin errors++; $display("FAIL debug t=%0d led got %0b exp %0b", t, led_out, m_led(t, 3, 1, 1)); end
      checks++; if (done !== m_done(t, 3, 1, 1)) begin errors++; $display("FAIL debug t=%0d done got %0b exp %0b", t, done, m_done(t, 3, 1, 1)); end
    end
    e_debug = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_count = 4'd5;
    for (int t = 1; t <= 6; t++) begin
      next_cycle();
      req_valid = 1'b0;
      checks++; if (led_out !== m_led(t, 5, ON, OFF)) begin errors++; $display("FAIL rstmid t=%0d led got %0b exp %0b", t, led_out, m_led(t, 5, ON, OFF)); end
    end
    rst_n = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid done-in-reset got %0b exp 0", done); end
    next_cycle();
    checks++; if ({led_out, busy, done} !== 3'b000) begin errors++; $display("FAIL rstmid after-reset led/busy/done got %03b exp 000", {led_out, busy, done}); end
    rst_n = 1'b1;
    next_cycle();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid release ready got %0b exp 1", req_ready); end
    checks++; if ({led_out, busy, done} !== 3'b000) begin errors++; $display("FAIL rstmid release led/busy/done got %03b exp 000", {led_out, busy, done}); end
  endtask

`ifdef LED_FLASH_QUEUE_EN
  task automatic test_back_to_back();
    bit exp_ready;
    bit exp_done;
    // Second request made while the first is running goes to the pending slot
    req_valid = 1'b1; req_count = 4'd1;
    for (int t = 1; t <= 16; t++) begin
      next_cycle();
      req_valid = 1'b0;
      if (t == 2) begin
        req_valid = 1'b1; req_count = 4'd1;
      end
      exp_ready = !(t >= 3 && t <= 7);
      exp_done  = (t == 7) || (t == 14);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL b2b t=%0d ready got %0b exp %0b", t, req_ready, exp_ready); end
      checks++; if (led_out !== m_led(t, 2, ON, OFF)) begin errors++; $display("FAIL b2b t=%0d led got %0b exp %0b", t, led_out, m_led(t, 2, ON, OFF)); end
      checks++; if (busy !== m_busy(t, 2, ON, OFF)) begin errors++; $display("FAIL b2b t=%0d busy got %0b exp %0b", t, busy, m_busy(t, 2, ON, OFF)); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b t=%0d done got %0b exp %0b", t, done, exp_done); end
    end
    // Request landing on the final OFF edge starts with no idle gap
    req_valid = 1'b1; req_count = 4'd1;
    for (int t = 1; t <= 23; t++) begin
      next_cycle();
      req_valid = 1'b0;
      if (t == 7) begin
        req_valid = 1'b1; req_count = 4'd2;
      end
      exp_done = (t == 7) || (t == 21);
      checks++; if (led_out !== m_led(t, 3, ON, OFF)) begin errors++; $display("FAIL direct t=%0d led got %0b exp %0b", t, led_out, m_led(t, 3, ON, OFF)); end
      checks++; if (busy !== m_busy(t, 3, ON, OFF)) begin errors++; $display("FAIL direct t=%0d busy got %0b exp %0b", t, busy, m_busy(t, 3, ON, OFF)); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL direct t=%0d done got %0b exp %0b", t, done, exp_done); end
    end
  endtask
`else
  task automatic test_back_to_back();
    req_valid = 1'b1; req_count = 4'd1;
    for (int t = 1; t <= 14; t++) begin
      next_cycle();
      req_valid = 1'b0;
      if (t == 2) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b busy ready got %0b exp 0", req_ready); end
        req_valid = 1'b1; req_count = 4'd3;
      end
      checks++; if (led_out !== m_led(t, 1, ON, OFF)) begin errors++; $display("FAIL b2b t=%0d led got %0b exp %0b", t, led_out, m_led(t, 1, ON, OFF)); end
      checks++; if (busy !== m_busy(t, 1, ON, OFF)) begin errors++; $display("FAIL b2b t=%0d busy got %0b exp %0b", t, busy, m_busy(t, 1, ON, OFF)); end
      checks++; if (done !== m_done(t, 1, ON, OFF)) begin errors++; $display("FAIL b2b t=%0d done got %0b exp %0b", t, done, m_done(t, 1, ON, OFF)); end
    end
  endtask
`endif

  task automatic test_random();
    int n;
    int on;
    int off;
    int total;
    bit dbg;
    for (int it = 0; it < 12; it++) begin
      n   = $urandom_range(0, 6);
      dbg = 1'($urandom_range(0, 1));
      on  = dbg ? 1 : ON;
      off = dbg ? 1 : OFF;
      e_debug = dbg;
      total = n * (on + off) + 2;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rand it=%0d ready0 got %0b exp 1", it, req_ready); end
      req_valid = 1'b1; req_count = 4'(n);
      for (int t = 1; t <= total; t++) begin
        next_cycle();
        req_valid = 1'b0;
`ifndef LED_FLASH_QUEUE_EN
        if (m_busy(t, n, on, off)) begin
          req_valid = 1'($urandom_range(0, 1));
          req_count = 4'($urandom_range(0, 15));
        end
        checks++; if (req_ready !== !m_busy(t, n, on, off)) begin errors++; $display("FAIL rand it=%0d t=%0d ready got %0b exp %0b", it, t, req_ready, !m_busy(t, n, on, off)); end
`endif
        checks++; if (led_out !== m_led(t, n, on, off)) begin errors++; $display("FAIL rand it=%0d n=%0d dbg=%0b t=%0d led got %0b exp %0b", it, n, dbg, t, led_out, m_led(t, n, on, off)); end
        checks++; if (busy !== m_busy(t, n, on, off)) begin errors++; $display("FAIL rand it=%0d n=%0d t=%0d busy got %0b exp %0b", it, n, t, busy, m_busy(t, n, on, off)); end
        checks++; if (done !== m_done(t, n, on, off)) begin errors++; $display("FAIL rand it=%0d n=%0d t=%0d done got %0b exp %0b", it, n, t, done, m_done(t, n, on, off)); end
      end
      req_valid = 1'b0;
    end
    e_debug = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0; e_debug = 1'b0; req_valid = 1'b0; req_count = 4'd0;
    test_reset();
    test_single_flash();
    test_zero_count();
    test_debug();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/led_flash_driver.md
LED_FLASH_DRIVER -- requirements
Module: led_flash_driver

Interface
REQ-001 Parameter CLKS_ON, default 250000: length of the LED-on phase in clk cycles (10 ms at 25 MHz); legal range 1 or more.
REQ-002 Parameter CLKS_OFF, default 250000: length of the LED-off phase in clk cycles; legal range 1 or more.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 e_debug  input  1  debug mode; every on/off phase lasts exactly 1 cycle.
REQ-006 req_valid  input  1  flash request strobe.
REQ-007 req_count  input  4  number of flashes requested (0..15).
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 led_out  output  1  LED drive, active-high.
REQ-010 busy  output  1  high while a flash sequence is in progress.
REQ-011 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-012 A request is accepted on a rising edge where req_valid and req_ready are both 1; req_count is captured on that edge.
REQ-013 The FSM has three states: IDLE, ON, OFF.
REQ-014 IDLE→ON on accept with req_count>0; the remaining-flash count loads req_count, and the phase counter clears.
REQ-015 An accepted request with req_count==0 is discarded; no flash, no done, state stays IDLE.
REQ-016 led_out=1 exactly in ON; it rises on the first cycle after the accepting edge (latency 1).
REQ-017 ON lasts CLKS_ON cycles, then ON→OFF; OFF lasts CLKS_OFF cycles (both 1 when e_debug=1, sampled each cycle).
REQ-018 At the end of OFF the remaining count decrements; nonzero→ON, zero→IDLE with done=1 for that one cycle.
REQ-019 busy=1 whenever the state is not IDLE.
REQ-020 Without the queue, req_ready = (state==IDLE); requests while busy are ignored.
REQ-021 The phase counter width is $clog2(max(CLKS_ON,CLKS_OFF))+1; the counter never wraps, because it clears at each phase change.
REQ-022 Toggling e_debug mid-phase ends the current phase on the next cycle if the elapsed count ≥1 under debug timing; there is no glitch on led_out beyond the phase boundary.

Reset
REQ-023 While rst_n=0 at a clock edge: state=IDLE, led_out=0, busy=0, done=0, counters=0, pending entry cleared.
REQ-024 Reset mid-sequence aborts it with no done pulse; req_ready=1 on the first cycle after reset release.

Configuration
REQ-025 Macro LED_FLASH_QUEUE_EN, when defined, compiles in a one-entry pending-request buffer.
REQ-026 With the macro: req_ready = IDLE or pending empty; an accept while busy stores req_count in pending (count 0 discarded).
REQ-027 With the macro: at the end of the final OFF phase, if pending is valid, the next state is ON with the pending count, done still pulses, and pending clears.
REQ-028 With the macro: an accept on the same edge as the final OFF end with pending empty starts that request directly (ON next cycle), so there is no gap.
REQ-029 Without the macro, there is no pending storage and REQ-020 applies.

Structure
REQ-030 Package led_flash_pkg holds the state encoding localparams (ST_IDLE, ST_ON, ST_OFF) and the count width constant (4).
REQ-031 Phase timing is a sub-module, led_phase_timer (load/clear, tick, terminal-count flag); the FSM and queue stay in the top level.

Verification
(bench parameters CLKS_ON=4, CLKS_OFF=3, e_debug=0 unless stated)
REQ-032 Reset, then req_count=2 accepted at cycle 0 → led_out 1 for cycles 1-4, 0 for cycles 5-7, 1 for cycles 8-11, 0 for cycles 12-14; done=1 at cycle 14, busy=0 at cycle 15.
REQ-033 req_count=0 accepted → busy, led_out and done stay 0 for 20 cycles.
REQ-034 e_debug=1, req_count=3 → led_out pattern 1,0,1,0,1,0; done on the 6th cycle.
REQ-035 rst_n=0 at cycle 6 of a req_count=5 sequence → led_out=0 next cycle, no done; req_ready=1 after release.
REQ-036 Without the macro: request while busy → req_ready=0 and the request is ignored. With LED_FLASH_QUEUE_EN: req_count=1 then req_count=1 while busy → two flashes separated only by the OFF phase, two done pulses, req_ready=0 while pending is full.
